// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared MDctrl op codes and FSM state encoding for the multiply/divide unit
package md_pkg;

  // Must track the decoder's MDctrl encoding.
  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational full-width multiply/divide result for one MDctrl op
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               s_ovf;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   safe_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   q_u;
  logic [WIDTH-1:0]   r_u;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign b_zero = (b == '0);
  assign s_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Signed divide runs on magnitudes; the most-negative dividend's magnitude
  // is still representable as an unsigned WIDTH-bit value.
  assign mag_a  = a_neg ? (~a + 1'b1) : a;
  assign mag_b  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? (~b + 1'b1) : b);
  assign safe_b = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign q_mag  = mag_a / mag_b;
  assign r_mag  = mag_a % mag_b;
  assign q_u    = a / safe_b;
  assign r_u    = a % safe_b;

  always_comb begin
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (b_zero) begin
          div_by_zero = 1'b1;
        end else if (s_ovf) begin
          res_lo = a;
          res_hi = '0;
        end else begin
          res_lo = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
          res_hi = a_neg ? (~r_mag + 1'b1) : r_mag;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          div_by_zero = 1'b1;
        end else begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle multiply/divide unit owning HI/LO with start/busy/cancel
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hilo_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state;
  md_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pending_hi;
  logic [WIDTH-1:0] pending_lo;
  logic             pending_dbz;
  logic             accept;
  logic             accept_long;
  logic             commit;
  logic             abort;
  logic [WIDTH-1:0] arith_hi;
  logic [WIDTH-1:0] arith_lo;
  logic             arith_dbz;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op          (md_op),
    .a           (src_a),
    .b           (src_b),
    .res_hi      (arith_hi),
    .res_lo      (arith_lo),
    .div_by_zero (arith_dbz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    accept_long = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          accept = 1'b1;
          if (is_long_op(md_op)) begin
            accept_long = 1'b1;
            state_n     = BUSY;
          end
        end
      end
      BUSY: begin
        // Cancel wins over a coinciding completion so a flushed op never commits.
        if (cancel) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pending_hi  <= '0;
      pending_lo  <= '0;
      pending_dbz <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      if (accept_long) begin
        pending_hi  <= arith_hi;
        pending_lo  <= arith_lo;
        pending_dbz <= arith_dbz;
        cnt         <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
      end else if (state == BUSY && !abort && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (accept && md_op == MD_MTHI) hi <= src_a;
      if (accept && md_op == MD_MTLO) lo <= src_a;

      if (commit && !pending_dbz) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end

      if (abort) begin
        cnt         <= '0;
        pending_hi  <= '0;
        pending_lo  <= '0;
        pending_dbz <= 1'b0;
      end
    end
  end

  assign busy    = (state == BUSY);
  assign rd_data = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard-based self-checking bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ohi, input logic [31:0] olo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin q = sa * sb; p = q; return p; end
      OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; return p; end
      OP_DIV: begin
        if (b == 0) return {ohi, olo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {ohi, olo};
        return {a % b, a / b};
      end
      default: return {ohi, olo};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
  endtask

  task automatic run_long(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    exp_t e;
    int n;
    sb_q.push_back('{name, exp_hi, exp_lo, (op == OP_MULT || op == OP_MULTU) ? 5 : 10});
    issue(op, a, b);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    checks++;
    if (n !== e.lat) begin failures++; $display("FAIL %s_busy_cycles actual=%0d required=%0d", e.name, n, e.lat); end
    checks++;
    if (hi !== e.hi) begin failures++; $display("FAIL %s_hi actual=%h required=%h", e.name, hi, e.hi); end
    checks++;
    if (lo !== e.lo) begin failures++; $display("FAIL %s_lo actual=%h required=%h", e.name, lo, e.lo); end
    hilo_sel = 1'b1; #1;
    checks++;
    if (rd_data !== e.hi) begin failures++; $display("FAIL %s_rd_hi actual=%h required=%h", e.name, rd_data, e.hi); end
    hilo_sel = 1'b0; #1;
    checks++;
    if (rd_data !== e.lo) begin failures++; $display("FAIL %s_rd_lo actual=%h required=%h", e.name, rd_data, e.lo); end
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    issue(OP_MTHI, h, 32'h0);
    issue(OP_MTLO, l, 32'h0);
    cur_hi = h;
    cur_lo = l;
    checks++;
    if (hi !== h || lo !== l) begin failures++; $display("FAIL set_hilo actual=%h_%h required=%h_%h", hi, lo, h, l); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = OP_NONE; src_a = 0; src_b = 0; cancel = 1'b0; hilo_sel = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || rd_data !== 32'h0) begin
      failures++; $display("FAIL reset_state actual=busy%b hi=%h lo=%h rd=%h required=0", busy, hi, lo, rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    run_long("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_long("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
  endtask

  task automatic test_div;
    run_long("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    set_hilo(32'h11, 32'h22);
    run_long("div_zero", OP_DIV, 32'd1234, 32'd0, 32'h11, 32'h22);
    run_long("divu_zero", OP_DIVU, 32'd99, 32'd0, 32'h11, 32'h22);
    run_long("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      op = 3'(1 + $urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      m  = model(op, a, b, cur_hi, cur_lo);
      run_long($sformatf("rand%0d", i), op, a, b, m[63:32], m[31:0]);
    end
  endtask

  task automatic test_mt;
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    md_op = OP_MTLO; src_a = 32'h0000_1234;
    checks++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      failures++; $display("FAIL mthi actual=hi%h busy%b required=hi deadbeef busy0", hi, busy);
    end
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h0000_1234 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo actual=hi%h lo%h busy%b required=deadbeef 00001234 0", hi, lo, busy);
    end
    hilo_sel = 1'b1; #1;
    checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mt_rd_hi actual=%h required=deadbeef", rd_data); end
    hilo_sel = 1'b0; #1;
    checks++;
    if (rd_data !== 32'h0000_1234) begin failures++; $display("FAIL mt_rd_lo actual=%h required=00001234", rd_data); end
    cur_hi = 32'hDEAD_BEEF;
    cur_lo = 32'h0000_1234;
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    start = 1'b1; md_op = OP_MULT; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
    @(negedge clk);
    md_op = OP_MTHI; src_a = 32'hCAFE_0000;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 5) begin failures++; $display("FAIL b2b_busy_cycles actual=%0d required=5", n); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL b2b_commit actual=%h_%h required=ffffffff_fffffffa", hi, lo);
    end
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    checks++;
    if (hi !== 32'hCAFE_0000 || lo !== 32'hFFFF_FFFA || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_mthi_after actual=%h_%h busy%b required=cafe0000_fffffffa busy0", hi, lo, busy);
    end
    cur_hi = 32'hCAFE_0000;
    cur_lo = 32'hFFFF_FFFA;
  endtask

  task automatic test_cancel;
    set_hilo(32'h55, 32'h66);
    issue(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy actual=%b required=0", busy); end
    repeat (6) @(negedge clk);
    checks++;
    if (hi !== 32'h55 || lo !== 32'h66 || busy !== 1'b0) begin
      failures++; $display("FAIL cancel_hilo actual=%h_%h busy%b required=00000055_00000066 busy0", hi, lo, busy);
    end
    start = 1'b1; md_op = OP_MTHI; src_a = 32'h99; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE; cancel = 1'b0;
    checks++;
    if (hi !== 32'h55) begin failures++; $display("FAIL cancel_idle_block actual=%h required=00000055", hi); end
    start = 1'b1; md_op = OP_DIV; src_a = 32'd100; src_b = 32'd7; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cancel_idle_long actual=%b required=0", busy); end
  endtask

  task automatic test_async_reset;
    issue(OP_MULT, 32'd6, 32'd7);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL async_reset actual=busy%b hi=%h lo=%h required=0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_discard actual=busy%b hi=%h lo=%h required=0", busy, hi, lo);
    end
    cur_hi = 32'h0;
    cur_lo = 32'h0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_random();
    test_back_to_back();
    test_cancel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
